// File: rtl/shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// shift_reg_pkg
//   Shared encodings for the shift_reg_en block.
//   - mode_e  : operation select carried on the 2-bit mode port
//   - state_e : transfer-tracking FSM states (IDLE / ACTIVE)
//   - is_shift: true for the two modes that move data one position and
//               therefore count towards a completed transfer
// ---------------------------------------------------------------------------
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // A rotate uses the same mode codes as a shift, so it counts the same way.
  function automatic logic is_shift(input logic [1:0] m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage : shift_reg_pkg

// File: rtl/dff_en_rst.sv
// ---------------------------------------------------------------------------
// dff_en_rst
//   One storage bit of the shift register: D flip-flop with clock enable and
//   synchronous active-high reset to a per-bit reset value.
// Ports
//   clk     in  rising-edge clock
//   reset   in  synchronous active-high reset (overrides en)
//   en      in  clock enable; 0 keeps the stored bit
//   d       in  next data bit
//   rst_val in  value stored on reset
//   q       out stored bit
// ---------------------------------------------------------------------------
module dff_en_rst (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  input  logic rst_val,
  output logic q
);

  logic q_q;
  logic q_d;

  // Next value: take d when enabled, otherwise recirculate.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end else begin
      q_d = q_q;
    end
  end

  // Storage flop with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= rst_val;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : dff_en_rst

// File: rtl/shift_reg_en.sv
// ---------------------------------------------------------------------------
// shift_reg_en
//   WIDTH-bit bidirectional shift register with clock enable, parallel load
//   and a transfer tracker: after a load the block is busy until WIDTH
//   shifts have been made, then pulses done for one cycle.
//
//   Optional feature macro: SHIFT_ROTATE_EN
//     defined   -> rot=1 turns shift right/left into rotate right/left
//     undefined -> rot is ignored and no rotate path exists
//
// Parameters
//   WIDTH     register width, 2..32
//   RESET_VAL value loaded into q on reset
// Ports
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset
//   en     in  clock enable; 0 freezes q, cnt and state (done drops to 0)
//   mode   in  00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d_par  in  parallel load data
//   d_sr   in  serial input into q[WIDTH-1] on shift right
//   d_sl   in  serial input into q[0] on shift left
//   rot    in  rotate request (only with SHIFT_ROTATE_EN)
//   q      out register contents
//   so_r   out q[0]
//   so_l   out q[WIDTH-1]
//   cnt    out shifts counted since the last load
//   busy   out high while a transfer is in progress (state ACTIVE)
//   done   out one-cycle pulse after the WIDTH-th counted shift
// ---------------------------------------------------------------------------
module shift_reg_en
  import shift_reg_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [WIDTH-1:0]          d_par,
  input  logic                      d_sr,
  input  logic                      d_sl,
  input  logic                      rot,
  output logic [WIDTH-1:0]          q,
  output logic                      so_r,
  output logic                      so_l,
  output logic [$clog2(WIDTH)-1:0]  cnt,
  output logic                      busy,
  output logic                      done
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] q_d;
  state_e           state_q;
  state_e           state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             done_q;
  logic             done_d;

`ifndef SHIFT_ROTATE_EN
  // rot has no function in this build.
  logic unused_rot_s;
  assign unused_rot_s = rot;
`endif

  // Data path: next register contents for the selected operation.
  always_comb begin
    q_d = q_s;
    if (en) begin
      case (mode_e'(mode))
        MODE_HOLD: q_d = q_s;
        MODE_SHR: begin
`ifdef SHIFT_ROTATE_EN
          if (rot) begin
            q_d = {q_s[0], q_s[WIDTH-1:1]};
          end else begin
            q_d = {d_sr, q_s[WIDTH-1:1]};
          end
`else
          q_d = {d_sr, q_s[WIDTH-1:1]};
`endif
        end
        MODE_SHL: begin
`ifdef SHIFT_ROTATE_EN
          if (rot) begin
            q_d = {q_s[WIDTH-2:0], q_s[WIDTH-1]};
          end else begin
            q_d = {q_s[WIDTH-2:0], d_sl};
          end
`else
          q_d = {q_s[WIDTH-2:0], d_sl};
`endif
        end
        MODE_LOAD: q_d = d_par;
        default:   q_d = q_s;
      endcase
    end else begin
      q_d = q_s;
    end
  end

  // Storage: one enabled, resettable flop per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_en_rst u_bit (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .d       (q_d[i]),
      .rst_val (RESET_VAL[i]),
      .q       (q_s[i])
    );
  end

  // Transfer tracker next state: a load starts/restarts a transfer, counted
  // shifts advance it, and the WIDTH-th shift ends it with a done pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (en) begin
      if (mode == MODE_LOAD) begin
        state_d = ACTIVE;
        cnt_d   = {CW{1'b0}};
      end else if (is_shift(mode) && (state_q == ACTIVE)) begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
          done_d  = 1'b1;
        end else begin
          state_d = ACTIVE;
          cnt_d   = cnt_q + CW'(1'b1);
        end
      end else begin
        // Hold, or a shift while IDLE: tracker untouched.
        state_d = state_q;
        cnt_d   = cnt_q;
      end
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  // Tracker registers; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_s;
  assign so_r = q_s[0];
  assign so_l = q_s[WIDTH-1];
  assign cnt  = cnt_q;
  assign busy = (state_q == ACTIVE);
  assign done = done_q;

endmodule : shift_reg_en
